// File: rtl/config_pkg.sv
// Core configuration package: only the fields consumed by the PTW request arbiter.
package config_pkg;

    typedef struct packed {
        int unsigned VLEN;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{VLEN: 32'd64};

endpackage

// File: rtl/ptw_req_arbiter.sv
// Shares one page-table walker between ITLB and DTLB misses, with walk timeout and flush handling.
// Define PTW_ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests; default build gives DTLB priority.
//
//   state | meaning
//   IDLE  | no walk outstanding; arbitrates pending requests
//   REQ   | ptw_req_o asserted, waiting for ptw_gnt_i
//   WAIT  | walk accepted, counting towards timeout
//   DRAIN | owner already answered or flushed; swallow the late ptw_done_i
module ptw_req_arbiter #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg       = config_pkg::cva6_cfg_empty,
    parameter int unsigned           TimeoutCycles = 256
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    input  logic                    itlb_req_i,
    input  logic [CVA6Cfg.VLEN-1:0] itlb_vaddr_i,
    input  logic                    dtlb_req_i,
    input  logic [CVA6Cfg.VLEN-1:0] dtlb_vaddr_i,
    input  logic                    dtlb_is_store_i,
    output logic                    ptw_req_o,
    output logic [CVA6Cfg.VLEN-1:0] ptw_vaddr_o,
    output logic                    ptw_is_instr_o,
    output logic                    ptw_is_store_o,
    input  logic                    ptw_gnt_i,
    input  logic                    ptw_done_i,
    input  logic                    ptw_error_i,
    output logic                    itlb_done_o,
    output logic                    dtlb_done_o,
    output logic                    itlb_err_o,
    output logic                    dtlb_err_o,
    output logic                    busy_o
);

    localparam int unsigned VLEN      = CVA6Cfg.VLEN;
    localparam logic [15:0] CNT_LIMIT = 16'(TimeoutCycles - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DRAIN
    } state_e;

    state_e          state_q, state_d;
    logic [VLEN-1:0] vaddr_q, vaddr_d;
    logic            is_instr_q, is_instr_d;
    logic            is_store_q, is_store_d;
    logic [15:0]     cnt_q, cnt_d;
    logic            itlb_done_q, itlb_done_d;
    logic            dtlb_done_q, dtlb_done_d;
    logic            itlb_err_q, itlb_err_d;
    logic            dtlb_err_q, dtlb_err_d;
    logic            grant_dtlb;

`ifdef PTW_ARB_ROUND_ROBIN_EN
    logic last_dtlb_q, last_dtlb_d;

    always_comb begin
        if (itlb_req_i && dtlb_req_i) begin
            grant_dtlb = ~last_dtlb_q;
        end else begin
            grant_dtlb = dtlb_req_i;
        end
    end

    // Pointer tracks the winner of every IDLE-to-REQ transition, flushed or not.
    always_comb begin
        last_dtlb_d = last_dtlb_q;
        if (state_q == IDLE && state_d == REQ) begin
            last_dtlb_d = grant_dtlb;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_dtlb_q <= 1'b0;
        end else begin
            last_dtlb_q <= last_dtlb_d;
        end
    end
`else
    assign grant_dtlb = dtlb_req_i;
`endif

    always_comb begin
        state_d     = state_q;
        vaddr_d     = vaddr_q;
        is_instr_d  = is_instr_q;
        is_store_d  = is_store_q;
        cnt_d       = cnt_q;
        itlb_done_d = 1'b0;
        dtlb_done_d = 1'b0;
        itlb_err_d  = 1'b0;
        dtlb_err_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!flush_i && (itlb_req_i || dtlb_req_i)) begin
                    state_d    = REQ;
                    vaddr_d    = grant_dtlb ? dtlb_vaddr_i : itlb_vaddr_i;
                    is_instr_d = ~grant_dtlb;
                    is_store_d = grant_dtlb & dtlb_is_store_i;
                end
            end
            REQ: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (ptw_gnt_i) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                // Flush beats completion, completion beats timeout.
                if (flush_i) begin
                    state_d = ptw_done_i ? IDLE : DRAIN;
                end else if (ptw_done_i) begin
                    state_d     = IDLE;
                    itlb_done_d = is_instr_q;
                    dtlb_done_d = ~is_instr_q;
                    itlb_err_d  = is_instr_q & ptw_error_i;
                    dtlb_err_d  = ~is_instr_q & ptw_error_i;
                end else if (cnt_q >= CNT_LIMIT) begin
                    state_d     = DRAIN;
                    itlb_done_d = is_instr_q;
                    dtlb_done_d = ~is_instr_q;
                    itlb_err_d  = is_instr_q;
                    dtlb_err_d  = ~is_instr_q;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DRAIN: begin
                if (ptw_done_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            vaddr_q     <= '0;
            is_instr_q  <= 1'b0;
            is_store_q  <= 1'b0;
            cnt_q       <= '0;
            itlb_done_q <= 1'b0;
            dtlb_done_q <= 1'b0;
            itlb_err_q  <= 1'b0;
            dtlb_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            vaddr_q     <= vaddr_d;
            is_instr_q  <= is_instr_d;
            is_store_q  <= is_store_d;
            cnt_q       <= cnt_d;
            itlb_done_q <= itlb_done_d;
            dtlb_done_q <= dtlb_done_d;
            itlb_err_q  <= itlb_err_d;
            dtlb_err_q  <= dtlb_err_d;
        end
    end

    assign ptw_req_o      = (state_q == REQ);
    assign ptw_vaddr_o    = vaddr_q;
    assign ptw_is_instr_o = is_instr_q;
    assign ptw_is_store_o = is_store_q;
    assign itlb_done_o    = itlb_done_q;
    assign dtlb_done_o    = dtlb_done_q;
    assign itlb_err_o     = itlb_err_q;
    assign dtlb_err_o     = dtlb_err_q;
    assign busy_o         = (state_q != IDLE);

endmodule

// File: doc/ptw_req_arbiter.md
PTW_REQ_ARBITER -- requrequirements

Module: ptw_req_arbiter

Interface
REQ-001 SHALL have parameter CVA6Cfg, default config_pkg::cva6_cfg_empty, core configuration; address width is CVA6Cfg.VLEN.
REQ-002 SHALL have parameter TimeoutCycles, default 256, maximum walk duration in cycles before abort; legal range 2..65535.
REQ-003 SHALL have port clk_i  in  1  single clock, rising edge.
REQ-004 SHALL have port rst_ni  in  1  asynchronous active-low reset.
REQ-005 SHALL have port flush_i  in  1  pipeline flush; abandons the pending request.
REQ-006 SHALL have port itlb_req_i / itlb_vaddr_i  in  1 / VLEN  ITLB miss request and address, held until itlb_done_o.
REQ-007 SHALL have port dtlb_req_i / dtlb_vaddr_i / dtlb_is_store_i  in  1 / VLEN / 1  DTLB miss request, address and store flag, held until dtlb_done_o.
REQ-008 SHALL have port ptw_req_o / ptw_vaddr_o / ptw_is_instr_o / ptw_is_store_o  out  1 / VLEN / 1 / 1  walk request to the shared PTW.
REQ-009 SHALL have port ptw_gnt_i  in  1  PTW accepts the request in the cycle ptw_req_o & ptw_gnt_i.
REQ-010 SHALL have port ptw_done_i / ptw_error_i  in  1 / 1  walk completion pulse and fault flag.
REQ-011 SHALL have port itlb_done_o / dtlb_done_o / itlb_err_o / dtlb_err_o  out  1 each  one-cycle completion and error pulses to requesters.
REQ-012 SHALL have port busy_o  out  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, REQ, WAIT, DRAIN.
REQ-014 IDLE: on any request with flush_i low, SHALL latch the winner's address and flags, record the owner, and enter REQ; ptw_req_o rises the next cycle (1-cycle latency).
REQ-015 REQ: ptw_req_o high and outputs stable until ptw_gnt_i, then enter WAIT with the timeout counter cleared to 0.
REQ-016 WAIT: the counter SHALL increment by 1 per cycle and saturate.
REQ-017 WAIT: on ptw_done_i, the owner's done_o SHALL pulse the next cycle, its err_o SHALL equal the registered ptw_error_i, and the FSM SHALL return to IDLE.
REQ-018 WAIT: when the counter reaches TimeoutCycles-1 without ptw_done_i, the owner's done_o and err_o SHALL both pulse and the FSM SHALL enter DRAIN.
REQ-019 flush_i in REQ SHALL drop ptw_req_o the next cycle and return to IDLE; no done pulse is produced.
REQ-020 flush_i in WAIT SHALL enter DRAIN with no done pulse.
REQ-021 DRAIN: SHALL wait for ptw_done_i, discard the result, then return to IDLE; flush_i has no effect.
REQ-022 When ptw_done_i and flush_i coincide in WAIT, flush SHALL win and the result is discarded (return to IDLE, no pulse).
REQ-023 When ptw_done_i arrives in the cycle the counter hits its limit, completion SHALL win over timeout.
REQ-024 A requester's done_o and err_o SHALL never pulse in the same cycle as the other requester's.
REQ-025 A request from the non-owner arriving while not IDLE SHALL wait and be arbitrated on return to IDLE.

Reset
REQ-026 Asserting rst_ni SHALL force IDLE immediately, including mid-walk.
REQ-027 Reset SHALL drive all outputs to 0, clear the counter to 0, and set the round-robin pointer to "ITLB last".

Configuration
REQ-028 The feature SHALL be controlled by macro PTW_ARB_ROUND_ROBIN_EN.
REQ-029 With the macro defined, simultaneous requests SHALL be granted to the requester not granted last, and the pointer SHALL update on each IDLE-to-REQ transition.
REQ-030 With the macro undefined, DTLB SHALL always win simultaneous requests and no pointer register SHALL exist.

Verification
REQ-031 Check: ITLB request at vaddr 0x8000_1000, ptw_gnt_i after 2 cycles, ptw_done_i 5 cycles later -> ptw_is_instr_o=1, single itlb_done_o pulse, itlb_err_o=0.
REQ-032 Check: both requests in the same cycle out of reset with round-robin enabled -> DTLB first, then ITLB; with the macro undefined, DTLB first again on a repeat.
REQ-033 Check: TimeoutCycles=8, no ptw_done_i -> dtlb_done_o and dtlb_err_o pulse 8 cycles after grant; a later ptw_done_i is discarded in DRAIN.
REQ-034 Check: flush_i in REQ -> ptw_req_o low the next cycle, no done pulse; flush_i in WAIT plus done 3 cycles later -> no pulse, busy_o low after done.
REQ-035 Check: ptw_done_i with ptw_error_i=1 for a DTLB store request -> dtlb_err_o=1 and ptw_is_store_o=1 during the walk.
REQ-036 Check: rst_ni low in WAIT -> all outputs 0 asynchronously, IDLE after release.
